mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between IF fetch and MEM load/store.
// Define ARB_STATS_EN to add the saturating conflict_cnt output.
module mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             owner_dm;
   logic             last_dm;
   logic             pick_dm;
   logic             any_req;

   assign any_req = if_req | dm_req;
   // fetch gets its turn right after a data grant, so conflicts alternate
   assign pick_dm = dm_req & ~(last_dm & if_req);
   assign stall   = (if_req & ~if_ack) | (dm_req & ~dm_ack);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         owner_dm  <= 1'b0;
         last_dm   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
`ifdef ARB_STATS_EN
         conflict_cnt <= '0;
`endif
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= ACCESS;
                  owner_dm <= pick_dm;
                  last_dm  <= pick_dm;
                  wait_cnt <= CNT_INIT;
                  mem_en   <= 1'b1;
                  mem_we   <= pick_dm & dm_we;
                  mem_addr <= pick_dm ? dm_addr : if_addr;
                  if (pick_dm & dm_we)
                     mem_wdata <= dm_wdata;
`ifdef ARB_STATS_EN
                  if (if_req & dm_req & (conflict_cnt != 16'hFFFF))
                     conflict_cnt <= conflict_cnt + 16'd1;
`endif
               end
            end
            ACCESS: begin
               if (wait_cnt == '0) begin
                  state  <= DONE;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (owner_dm) begin
                     dm_ack <= 1'b1;
                     if (!mem_we)
                        dm_rdata <= mem_rdata;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and a randomized
// transaction-level reference model for mem_arbiter.
module tb_mem_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int LAT  = 1;
   localparam int LAT3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          if_req, dm_req, dm_we, if_req3, dm_req3;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;

   logic          if_ack, dm_ack, mem_en, mem_we, stall;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic          if_ack3, dm_ack3, mem_en3, mem_we3, stall3;
   logic [DW-1:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
   logic [AW-1:0] mem_addr3;
`ifdef ARB_STATS_EN
   logic [15:0]   conflict_cnt, conflict_cnt3;
`endif

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall(stall)
`ifdef ARB_STATS_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req3), .if_addr(if_addr),
      .if_ack(if_ack3), .if_rdata(if_rdata3),
      .dm_req(dm_req3), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
      .stall(stall3)
`ifdef ARB_STATS_EN
      , .conflict_cnt(conflict_cnt3)
`endif
   );

   // memory returns valid data only in the last cycle of its latency window
   logic [DW-1:0] mem_arr [256];
   int acc = 0;
   int acc3 = 0;
   always @(posedge clk) begin
      acc  <= mem_en  ? acc + 1  : 0;
      acc3 <= mem_en3 ? acc3 + 1 : 0;
   end
   assign mem_rdata  = (mem_en && acc == LAT - 1) ? mem_arr[mem_addr] : 16'hDEAD;
   assign mem_rdata3 = (mem_en3 && acc3 == LAT3 - 1) ? mem_arr[mem_addr3] : 16'hDEAD;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
      if (mem_en && mem_we)
         mem_arr[mem_addr] = mem_wdata;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      if_req  = 1'b0;
      dm_req  = 1'b0;
      if_req3 = 1'b0;
      dm_req3 = 1'b0;
      cyc(); smp();
      cyc(); smp();
      cyc();
      reset = 1'b1;
      smp();
   endtask

   typedef struct {
      bit          dm;
      bit          we;
      bit          pre;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] mdata;
      logic [15:0] exp_if;
      logic [15:0] exp_dm;
   } vec_t;

   vec_t tbl [7];

   logic [DW-1:0] ref_mem [256];
   int   free_at, g, if_ack_c, dm_ack_c;
   logic m_last_dm, pick, g_we, dm_ld, prev_if_ack, prev_dm_ack, in_acc;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] hold_if, hold_dm, exp_if_d, exp_dm_d;
   int   m_conf;

   initial begin
      vec_t v;
      reset    = 1'b0;
      dm_we    = 1'b0;
      if_addr  = '0;
      dm_addr  = '0;
      dm_wdata = '0;
      for (int i = 0; i < 256; i++)
         mem_arr[i] = 16'(i * 257) ^ 16'h3C3C;

      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, 16'hA5A5, 16'hA5A5, 16'h0000};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h20, 16'h1234, 16'h0000, 16'hA5A5, 16'h0000};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h20, 16'h0000, 16'h0000, 16'hA5A5, 16'h1234};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 16'h8001, 16'hFFFF, 16'h8001};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'h5A5A, 16'h0000, 16'hFFFF, 16'h8001};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0000, 16'h5A5A, 16'h8001};

      do_reset();
      chk("rst_if_ack",    32'(if_ack), 0);
      chk("rst_dm_ack",    32'(dm_ack), 0);
      chk("rst_if_rdata",  32'(if_rdata), 0);
      chk("rst_dm_rdata",  32'(dm_rdata), 0);
      chk("rst_mem_en",    32'(mem_en), 0);
      chk("rst_mem_we",    32'(mem_we), 0);
      chk("rst_mem_addr",  32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_stall",     32'(stall), 0);
      chk("rst_mem_en3",   32'(mem_en3), 0);
`ifdef ARB_STATS_EN
      chk("rst_conflict",  32'(conflict_cnt), 0);
`endif

      // single transactions, MEM_LAT=1
      for (int i = 0; i < 7; i++) begin
         v = tbl[i];
         if (v.pre)
            mem_arr[v.addr] = v.mdata;
         cyc();
         if (v.dm) begin
            dm_req = 1'b1; dm_we = v.we;
            dm_addr = v.addr; dm_wdata = v.wdata;
         end else begin
            if_req = 1'b1; if_addr = v.addr;
         end
         smp();
         chk("t_c0_stall",  32'(stall), 1);
         chk("t_c0_mem_en", 32'(mem_en), 0);
         cyc(); smp();
         chk("t_c1_mem_en",   32'(mem_en), 1);
         chk("t_c1_mem_we",   32'(mem_we), 32'(v.we));
         chk("t_c1_mem_addr", 32'(mem_addr), 32'(v.addr));
         chk("t_c1_stall",    32'(stall), 1);
         chk("t_c1_acks",     32'({if_ack, dm_ack}), 0);
         if (v.we)
            chk("t_c1_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
         cyc(); smp();
         chk("t_c2_if_ack",   32'(if_ack), 32'(!v.dm));
         chk("t_c2_dm_ack",   32'(dm_ack), 32'(v.dm));
         chk("t_c2_mem_en",   32'(mem_en), 0);
         chk("t_c2_stall",    32'(stall), 0);
         chk("t_c2_if_rdata", 32'(if_rdata), 32'(v.exp_if));
         chk("t_c2_dm_rdata", 32'(dm_rdata), 32'(v.exp_dm));
         cyc();
         if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
         smp();
         chk("t_c3_acks",  32'({if_ack, dm_ack}), 0);
         chk("t_c3_stall", 32'(stall), 0);
         if (v.we)
            chk("t_store_landed", 32'(mem_arr[v.addr]), 32'(v.wdata));
      end

      // continuous conflict: data, fetch, data, fetch
      mem_arr[8'h30] = 16'h3030;
      mem_arr[8'h31] = 16'h3131;
      cyc();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30;
      if_req = 1'b1; if_addr = 8'h31;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc();
         smp();
         chk("alt_dm_ack", 32'(dm_ack), 32'(c == 2 || c == 8));
         chk("alt_if_ack", 32'(if_ack), 32'(c == 5 || c == 11));
         if (c % 3 == 1)
            chk("alt_grant_addr", 32'(mem_addr), (c % 6 == 1) ? 32'h30 : 32'h31);
         if (c == 2)
            chk("alt_dm_rdata", 32'(dm_rdata), 32'h3030);
         if (c == 5) begin
            chk("alt_if_rdata", 32'(if_rdata), 32'h3131);
`ifdef ARB_STATS_EN
            chk("alt_conflict_cnt", 32'(conflict_cnt), 2);
`endif
         end
      end
      cyc();
      dm_req = 1'b0; if_req = 1'b0;
      smp();
      chk("alt_end_acks", 32'({if_ack, dm_ack}), 0);

      // reset in the middle of an access
      mem_arr[8'h40] = 16'h7777;
      cyc();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h40;
      smp();
      chk("mr_c0_stall", 32'(stall), 1);
      cyc();
      reset = 1'b0;
      smp();
      chk("mr_c1_mem_en", 32'(mem_en), 1);
      cyc();
      reset = 1'b1; dm_req = 1'b0;
      smp();
      chk("mr_c2_mem_en",   32'(mem_en), 0);
      chk("mr_c2_dm_ack",   32'(dm_ack), 0);
      chk("mr_c2_if_rdata", 32'(if_rdata), 0);
      chk("mr_c2_dm_rdata", 32'(dm_rdata), 0);
      chk("mr_c2_mem_addr", 32'(mem_addr), 0);
`ifdef ARB_STATS_EN
      chk("mr_conflict_cnt", 32'(conflict_cnt), 0);
`endif
      cyc(); smp();
      chk("mr_c3_acks",   32'({if_ack, dm_ack}), 0);
      chk("mr_c3_mem_en", 32'(mem_en), 0);

      // first conflict after reset goes to data
      mem_arr[8'h41] = 16'h1111;
      mem_arr[8'h42] = 16'h2222;
      cyc();
      dm_req = 1'b1; dm_addr = 8'h41;
      if_req = 1'b1; if_addr = 8'h42;
      smp();
      cyc(); smp();
      chk("pr_c1_mem_addr", 32'(mem_addr), 32'h41);
      chk("pr_c1_mem_en",   32'(mem_en), 1);
      cyc(); smp();
      chk("pr_c2_dm_ack",   32'(dm_ack), 1);
      chk("pr_c2_if_ack",   32'(if_ack), 0);
      chk("pr_c2_dm_rdata", 32'(dm_rdata), 32'h1111);
      cyc();
      dm_req = 1'b0;
      smp();
      chk("pr_c3_stall", 32'(stall), 1);
      cyc(); smp();
      chk("pr_c4_mem_addr", 32'(mem_addr), 32'h42);
      cyc(); smp();
      chk("pr_c5_if_ack",   32'(if_ack), 1);
      chk("pr_c5_if_rdata", 32'(if_rdata), 32'h2222);
`ifdef ARB_STATS_EN
      chk("pr_conflict_cnt", 32'(conflict_cnt), 1);
`endif
      cyc();
      if_req = 1'b0;
      smp();
      chk("pr_c6_if_ack", 32'(if_ack), 0);

      // randomized traffic against a transaction-level model
      do_reset();
      for (int i = 0; i < 256; i++)
         ref_mem[i] = mem_arr[i];
      free_at = 0; g = -100; if_ack_c = -1; dm_ack_c = -1;
      m_last_dm = 1'b0; g_we = 1'b0; dm_ld = 1'b0; g_addr = '0;
      hold_if = '0; hold_dm = '0; exp_if_d = '0; exp_dm_d = '0;
      prev_if_ack = 1'b0; prev_dm_ack = 1'b0; m_conf = 0;
      for (int c = 0; c < 600; c++) begin
         cyc();
         if (if_req && prev_if_ack)
            if_req = 1'b0;
         else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = 8'($urandom_range(0, 15));
         end
         if (dm_req && prev_dm_ack)
            dm_req = 1'b0;
         else if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req = 1'b1;
            dm_we = 1'($urandom_range(0, 1));
            dm_addr = 8'($urandom_range(0, 15));
            dm_wdata = 16'($urandom);
         end
         smp();
         if (c == if_ack_c) hold_if = exp_if_d;
         if (c == dm_ack_c && dm_ld) hold_dm = exp_dm_d;
         in_acc = (c > g) && (c <= g + LAT);
         chk("rnd_if_ack",   32'(if_ack), 32'(c == if_ack_c));
         chk("rnd_dm_ack",   32'(dm_ack), 32'(c == dm_ack_c));
         chk("rnd_if_rdata", 32'(if_rdata), 32'(hold_if));
         chk("rnd_dm_rdata", 32'(dm_rdata), 32'(hold_dm));
         chk("rnd_mem_en",   32'(mem_en), 32'(in_acc));
         chk("rnd_mem_we",   32'(mem_we), 32'(in_acc && g_we));
         chk("rnd_stall", 32'(stall),
             32'((if_req && c != if_ack_c) || (dm_req && c != dm_ack_c)));
         if (in_acc)
            chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
         prev_if_ack = (c == if_ack_c);
         prev_dm_ack = (c == dm_ack_c);
         if (c >= free_at && (if_req || dm_req)) begin
            pick = dm_req && !(m_last_dm && if_req);
            if (if_req && dm_req && m_conf < 65535) m_conf++;
            g = c;
            free_at = c + LAT + 2;
            m_last_dm = pick;
            g_we = pick && dm_we;
            g_addr = pick ? dm_addr : if_addr;
            if (pick) begin
               dm_ack_c = c + LAT + 1;
               dm_ld = !dm_we;
               if (dm_we) ref_mem[dm_addr] = dm_wdata;
               else exp_dm_d = ref_mem[dm_addr];
            end else begin
               if_ack_c = c + LAT + 1;
               exp_if_d = ref_mem[if_addr];
            end
         end
      end
      cyc(); smp();
`ifdef ARB_STATS_EN
      chk("rnd_conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
      if_req = 1'b0; dm_req = 1'b0;
      do_reset();

      // MEM_LAT=3 load; requester drops early but ack still comes
      mem_arr[8'h50] = 16'hC3C3;
      cyc();
      dm_req3 = 1'b1; dm_we = 1'b0; dm_addr = 8'h50;
      smp();
      chk("l3_c0_mem_en", 32'(mem_en3), 0);
      chk("l3_c0_stall",  32'(stall3), 1);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         if (c == 2) dm_req3 = 1'b0;
         smp();
         chk("l3_mem_en", 32'(mem_en3), 32'(c <= 3));
         chk("l3_dm_ack", 32'(dm_ack3), 32'(c == 4));
         if (c <= 3)
            chk("l3_mem_addr", 32'(mem_addr3), 32'h50);
         if (c >= 4)
            chk("l3_dm_rdata", 32'(dm_rdata3), 32'hC3C3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
